// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect controller: turns a resolved taken branch in EX into a
// fetch redirect, pipeline flushes and a short fetch drain; HALT parks the front end.
// Optional macro BRCTRL_STATS_EN adds a saturating redirect_count output.
module branch_redirect_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_pcselect,
   input  logic [15:0] ex_PCwb,
   input  logic [15:0] ex_PCnext,
   input  logic        halt_req,
   input  logic        stall,
`ifdef BRCTRL_STATS_EN
   output logic [15:0] redirect_count,
`endif
   output logic        redirect_valid,
   output logic [15:0] redirect_pc,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        fetch_hold,
   output logic        halted
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

   state_t      state_q;
   state_t      state_nxt;
   logic [15:0] target_q;
   logic [15:0] target_nxt;
   logic [2:0]  drain_cnt_q;
   logic [2:0]  drain_cnt_nxt;

   logic        accept;
   logic        taken;

   logic        redirect_valid_nxt;
   logic [15:0] redirect_pc_nxt;
   logic        flush_ifid_nxt;
   logic        flush_idex_nxt;
   logic        fetch_hold_nxt;
   logic        halted_nxt;

   assign accept = ex_valid & ~stall;
   // A branch whose resolved target equals fall-through costs nothing to keep.
   assign taken  = ex_pcselect & (ex_PCwb != ex_PCnext);

   always_comb begin
      state_nxt     = state_q;
      target_nxt    = target_q;
      drain_cnt_nxt = drain_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (halt_req) begin
                  state_nxt = HALTED;
               end else if (taken) begin
                  target_nxt = ex_PCwb;
                  state_nxt  = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            if (!stall) begin
               if (DRAIN_CYCLES > 0) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = DRAIN_INIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DRAIN: begin
            if (!stall) begin
               if (drain_cnt_q <= 3'd1) begin
                  state_nxt     = IDLE;
                  drain_cnt_nxt = 3'd0;
               end else begin
                  drain_cnt_nxt = drain_cnt_q - 3'd1;
               end
            end
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt     = IDLE;
            drain_cnt_nxt = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      redirect_valid_nxt = 1'b0;
      redirect_pc_nxt    = target_nxt;
      flush_ifid_nxt     = 1'b0;
      flush_idex_nxt     = 1'b0;
      fetch_hold_nxt     = 1'b0;
      halted_nxt         = 1'b0;
      case (state_nxt)
         REDIRECT: begin
            redirect_valid_nxt = 1'b1;
            flush_ifid_nxt     = 1'b1;
            flush_idex_nxt     = 1'b1;
         end
         DRAIN: begin
            flush_idex_nxt = 1'b1;
            fetch_hold_nxt = 1'b1;
         end
         HALTED: begin
            redirect_pc_nxt = 16'h0000;
            fetch_hold_nxt  = 1'b1;
            halted_nxt      = 1'b1;
         end
         default: begin
            redirect_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         target_q       <= 16'h0000;
         drain_cnt_q    <= 3'd0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 16'h0000;
         flush_ifid     <= 1'b0;
         flush_idex     <= 1'b0;
         fetch_hold     <= 1'b0;
         halted         <= 1'b0;
      end else begin
         state_q        <= state_nxt;
         target_q       <= target_nxt;
         drain_cnt_q    <= drain_cnt_nxt;
         redirect_valid <= redirect_valid_nxt;
         redirect_pc    <= redirect_pc_nxt;
         flush_ifid     <= flush_ifid_nxt;
         flush_idex     <= flush_idex_nxt;
         fetch_hold     <= fetch_hold_nxt;
         halted         <= halted_nxt;
      end
   end

`ifdef BRCTRL_STATS_EN
   logic redirect_entry;
   assign redirect_entry = (state_q == IDLE) && (state_nxt == REDIRECT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_count <= 16'h0000;
      end else if (redirect_entry && (redirect_count != 16'hFFFF)) begin
         redirect_count <= redirect_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, hand-written corner
// sequences and random traffic against a pending-cycle reference model.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_pcselect, halt_req, stall;
   logic [15:0] ex_PCwb, ex_PCnext;

   logic        a_rv, a_fi, a_fx, a_fh, a_ha;
   logic [15:0] a_pc;
   logic        b_rv, b_fi, b_fx, b_fh, b_ha;
   logic [15:0] b_pc;
`ifdef BRCTRL_STATS_EN
   logic [15:0] a_cnt, b_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.DRAIN_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pcselect(ex_pcselect),
      .ex_PCwb(ex_PCwb), .ex_PCnext(ex_PCnext), .halt_req(halt_req), .stall(stall),
`ifdef BRCTRL_STATS_EN
      .redirect_count(a_cnt),
`endif
      .redirect_valid(a_rv), .redirect_pc(a_pc), .flush_ifid(a_fi),
      .flush_idex(a_fx), .fetch_hold(a_fh), .halted(a_ha));

   branch_redirect_ctrl #(.DRAIN_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pcselect(ex_pcselect),
      .ex_PCwb(ex_PCwb), .ex_PCnext(ex_PCnext), .halt_req(halt_req), .stall(stall),
`ifdef BRCTRL_STATS_EN
      .redirect_count(b_cnt),
`endif
      .redirect_valid(b_rv), .redirect_pc(b_pc), .flush_ifid(b_fi),
      .flush_idex(b_fx), .fetch_hold(b_fh), .halted(b_ha));

   // Model: pend counts remaining non-stalled post-branch cycles (redirect + drain).
   int          dcy [2] = '{1, 3};
   int          pend [2];
   bit          m_halt [2];
   logic [15:0] m_tgt [2];
   int          m_cnt [2];

   typedef struct {
      bit v, p, h, s;
      logic [15:0] wb, nx;
      bit rv, fi, fx, fh, ha;
      logic [15:0] pc;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0; m_halt[i] = 0; m_tgt[i] = 16'h0000; m_cnt[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (m_halt[i]) begin
         end else if (pend[i] > 0) begin
            if (!stall) pend[i]--;
         end else if (ex_valid && !stall) begin
            if (halt_req) m_halt[i] = 1;
            else if (ex_pcselect && ex_PCwb != ex_PCnext) begin
               m_tgt[i] = ex_PCwb;
               pend[i] = dcy[i] + 1;
               if (m_cnt[i] < 65535) m_cnt[i]++;
            end
         end
      end
   endtask

   task automatic check_dut(input int i);
      bit rv, fi, fx, fh, ha;
      logic [15:0] pc;
      string n;
      rv = 0; fi = 0; fx = 0; fh = 0; ha = 0;
      if (m_halt[i]) begin ha = 1; fh = 1; end
      else if (pend[i] == dcy[i] + 1) begin rv = 1; fi = 1; fx = 1; end
      else if (pend[i] > 0) begin fh = 1; fx = 1; end
      n = (i == 0) ? "a" : "b";
      chk({n, ".redirect_valid"}, 32'(i ? b_rv : a_rv), 32'(rv));
      chk({n, ".flush_ifid"},     32'(i ? b_fi : a_fi), 32'(fi));
      chk({n, ".flush_idex"},     32'(i ? b_fx : a_fx), 32'(fx));
      chk({n, ".fetch_hold"},     32'(i ? b_fh : a_fh), 32'(fh));
      chk({n, ".halted"},         32'(i ? b_ha : a_ha), 32'(ha));
      pc = i ? b_pc : a_pc;
      if (!m_halt[i]) chk({n, ".redirect_pc"}, 32'(pc), 32'(m_tgt[i]));
`ifdef BRCTRL_STATS_EN
      chk({n, ".redirect_count"}, 32'(i ? b_cnt : a_cnt), 32'(m_cnt[i]));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic drive(input bit v, input bit p, input bit h, input bit s,
                        input logic [15:0] wb, input logic [15:0] nx);
      ex_valid = v; ex_pcselect = p; halt_req = h; stall = s;
      ex_PCwb = wb; ex_PCnext = nx;
   endtask

   // Asynchronous reset pulse placed mid-cycle, released before the next rising edge.
   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_dut(0);
      check_dut(1);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1,1,0,0,16'h0040,16'h0012, 1,1,1,0,0,16'h0040};
      tbl[1]  = '{0,0,0,0,16'h0000,16'h0000, 0,0,1,1,0,16'h0040};
      tbl[2]  = '{0,0,0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0040};
      tbl[3]  = '{1,1,0,0,16'h0012,16'h0012, 0,0,0,0,0,16'h0040};
      tbl[4]  = '{1,1,0,0,16'h0080,16'h0014, 1,1,1,0,0,16'h0080};
      tbl[5]  = '{0,0,0,1,16'h0000,16'h0000, 1,1,1,0,0,16'h0080};
      tbl[6]  = '{0,0,0,1,16'h0000,16'h0000, 1,1,1,0,0,16'h0080};
      tbl[7]  = '{0,0,0,1,16'h0000,16'h0000, 1,1,1,0,0,16'h0080};
      tbl[8]  = '{1,1,0,0,16'h0100,16'h0016, 0,0,1,1,0,16'h0080};
      tbl[9]  = '{0,0,0,0,16'h0000,16'h0000, 0,0,0,0,0,16'h0080};
      tbl[10] = '{1,1,0,1,16'h0200,16'h0016, 0,0,0,0,0,16'h0080};
      tbl[11] = '{1,1,1,0,16'h0300,16'h0018, 0,0,0,1,1,16'h0000};
      tbl[12] = '{1,1,0,0,16'h0400,16'h001a, 0,0,0,1,1,16'h0000};
      tbl[13] = '{0,0,0,0,16'h0000,16'h0000, 0,0,0,1,1,16'h0000};

      drive(0, 0, 0, 0, 16'h0000, 16'h0000);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
      @(negedge clk) rst_n = 1'b1;

      // Directed table against DRAIN_CYCLES=1 instance
      for (int k = 0; k < 14; k++) begin
         drive(tbl[k].v, tbl[k].p, tbl[k].h, tbl[k].s, tbl[k].wb, tbl[k].nx);
         tick();
         chk($sformatf("tbl[%0d].redirect_valid", k), 32'(a_rv), 32'(tbl[k].rv));
         chk($sformatf("tbl[%0d].flush_ifid", k),     32'(a_fi), 32'(tbl[k].fi));
         chk($sformatf("tbl[%0d].flush_idex", k),     32'(a_fx), 32'(tbl[k].fx));
         chk($sformatf("tbl[%0d].fetch_hold", k),     32'(a_fh), 32'(tbl[k].fh));
         chk($sformatf("tbl[%0d].halted", k),         32'(a_ha), 32'(tbl[k].ha));
         if (!tbl[k].ha) chk($sformatf("tbl[%0d].redirect_pc", k), 32'(a_pc), 32'(tbl[k].pc));
      end

      // Reset while halted, then reset in the second drain cycle of DRAIN_CYCLES=3
      reset_pulse();
      chk("post_halt_reset.halted", 32'(a_ha), 32'd0);
      drive(1, 1, 0, 0, 16'h0040, 16'h0012);
      tick();
      chk("b.redirect_entry", 32'(b_rv), 32'd1);
      drive(0, 0, 0, 0, 16'h0000, 16'h0000);
      tick();
      tick();
      chk("b.drain2.fetch_hold", 32'(b_fh), 32'd1);
      reset_pulse();
      chk("b.mid_drain_reset.fetch_hold", 32'(b_fh), 32'd0);
      chk("b.mid_drain_reset.redirect_pc", 32'(b_pc), 32'h0000);
      drive(1, 1, 0, 0, 16'h0060, 16'h0022);
      tick();
      chk("b.after_reset.redirect_valid", 32'(b_rv), 32'd1);
      chk("b.after_reset.redirect_pc", 32'(b_pc), 32'h0060);
      drive(0, 0, 0, 0, 16'h0000, 16'h0000);
      repeat (5) tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] nx;
         nx = 16'($urandom) & 16'hFFFE;
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 3, $urandom_range(0, 3) == 0,
               ($urandom_range(0, 1) == 1) ? nx : (16'($urandom) & 16'hFFFE), nx);
         tick();
         if ($urandom_range(0, 99) == 0 || (m_halt[0] && m_halt[1] && $urandom_range(0, 7) == 0))
            reset_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
